// File: rtl/freq_meas_sched.sv
// Sequences one shared frequency counter across N_CH pulse channels: mux select, settle, gate, collect.
// Optional WAIT timeout with res_err marking is built when FMS_TIMEOUT_EN is defined.
module freq_meas_sched #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CH_W    = 2,
  parameter int unsigned GATE_W  = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              continuous,
  output logic              fc_en,
  output logic [CH_W-1:0]   fc_sel,
  input  logic              fc_vld,
  input  logic [CNT_W-1:0]  fc_cnt,
  output logic              res_vld,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [CNT_W-1:0]  res_cnt,
  output logic              res_err,
  output logic              busy
);

  localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
  localparam int unsigned CYC_W = (GATE_W > TMO_W) ? GATE_W : TMO_W;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_GATE, S_WAIT, S_OUT} state_t;

  state_t            r_state,   w_state;
  logic [N_CH-1:0]   r_mask,    w_mask;
  logic [GATE_W-1:0] r_gate,    w_gate;
  logic [CYC_W-1:0]  r_cyc,     w_cyc;
  logic              r_fc_en,   w_fc_en;
  logic [CH_W-1:0]   r_fc_sel,  w_fc_sel;
  logic              r_res_vld, w_res_vld;
  logic [CH_W-1:0]   r_res_ch,  w_res_ch;
  logic [CNT_W-1:0]  r_res_cnt, w_res_cnt;
  logic              r_res_err, w_res_err;
  logic              r_busy,    w_busy;
  logic              w_has_next;
  logic [CH_W-1:0]   w_next_sel;

  function automatic logic [CH_W-1:0] f_lowest(input logic [N_CH-1:0] m);
    f_lowest = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--)
      if (m[i]) f_lowest = CH_W'(i);
  endfunction

  // Next enabled channel strictly above the current select, no wrap.
  always_comb begin
    w_has_next = 1'b0;
    w_next_sel = r_fc_sel;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (r_mask[i] && (CH_W'(i) > r_fc_sel)) begin
        w_has_next = 1'b1;
        w_next_sel = CH_W'(i);
      end
    end
  end

  always_comb begin
    w_state   = r_state;
    w_mask    = r_mask;
    w_gate    = r_gate;
    w_cyc     = r_cyc;
    w_fc_en   = r_fc_en;
    w_fc_sel  = r_fc_sel;
    w_res_vld = r_res_vld;
    w_res_ch  = r_res_ch;
    w_res_cnt = r_res_cnt;
    w_res_err = r_res_err;
    case (r_state)
      S_IDLE: begin
        if (start && (ch_mask != '0)) begin
          w_mask   = ch_mask;
          w_gate   = (gate_len == '0) ? GATE_W'(1) : gate_len;
          w_fc_sel = f_lowest(ch_mask);
          w_cyc    = '0;
          w_state  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cyc == CYC_W'(SETTLE - 1)) begin
          w_cyc   = '0;
          w_fc_en = 1'b1;
          w_state = S_GATE;
        end else begin
          w_cyc = r_cyc + CYC_W'(1);
        end
      end
      S_GATE: begin
        if (r_cyc == (CYC_W'(r_gate) - CYC_W'(1))) begin
          w_cyc   = '0;
          w_fc_en = 1'b0;
          w_state = S_WAIT;
        end else begin
          w_cyc = r_cyc + CYC_W'(1);
        end
      end
      S_WAIT: begin
        if (fc_vld) begin
          w_res_cnt = fc_cnt;
          w_res_ch  = r_fc_sel;
          w_res_err = 1'b0;
          w_res_vld = 1'b1;
          w_state   = S_OUT;
        end
`ifdef FMS_TIMEOUT_EN
        // A late fc_vld on the expiry cycle takes the branch above.
        else if (r_cyc == CYC_W'(TMO_CYC - 1)) begin
          w_res_cnt = '0;
          w_res_ch  = r_fc_sel;
          w_res_err = 1'b1;
          w_res_vld = 1'b1;
          w_state   = S_OUT;
        end else begin
          w_cyc = r_cyc + CYC_W'(1);
        end
`endif
      end
      S_OUT: begin
        if (res_ready) begin
          w_res_vld = 1'b0;
          w_cyc     = '0;
          if (w_has_next) begin
            w_fc_sel = w_next_sel;
            w_state  = S_SETTLE;
          end else if (continuous) begin
            w_fc_sel = f_lowest(r_mask);
            w_state  = S_SETTLE;
          end else begin
            w_state = S_IDLE;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mask    <= '0;
      r_gate    <= '0;
      r_cyc     <= '0;
      r_fc_en   <= 1'b0;
      r_fc_sel  <= '0;
      r_res_vld <= 1'b0;
      r_res_ch  <= '0;
      r_res_cnt <= '0;
      r_res_err <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_mask    <= w_mask;
      r_gate    <= w_gate;
      r_cyc     <= w_cyc;
      r_fc_en   <= w_fc_en;
      r_fc_sel  <= w_fc_sel;
      r_res_vld <= w_res_vld;
      r_res_ch  <= w_res_ch;
      r_res_cnt <= w_res_cnt;
      r_res_err <= w_res_err;
      r_busy    <= w_busy;
    end
  end

  assign fc_en   = r_fc_en;
  assign fc_sel  = r_fc_sel;
  assign res_vld = r_res_vld;
  assign res_ch  = r_res_ch;
  assign res_cnt = r_res_cnt;
  assign res_err = r_res_err;
  assign busy    = r_busy;

endmodule

// File: tb/tb_freq_meas_sched.sv
// Directed bench for freq_meas_sched with a behavioural frequency-counter model.
`timescale 1ns/1ps
module tb_freq_meas_sched;
  localparam int unsigned N_CH = 4, CH_W = 2, GATE_W = 16, CNT_W = 16, SETTLE = 4;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, continuous = 1'b0;
  logic [N_CH-1:0]   ch_mask = '0;
  logic [GATE_W-1:0] gate_len = '0;
  logic              fc_en, fc_vld = 1'b0, res_vld, res_ready = 1'b0, res_err, busy;
  logic [CH_W-1:0]   fc_sel, res_ch;
  logic [CNT_W-1:0]  fc_cnt = '0, res_cnt;

  int checks = 0, errors = 0;
  int cyc_m = 0, cnt_m = 0, dly = 0, en_run = 0, last_en_len = 0;
  bit en_seen = 0, model_en = 1;
  int period [N_CH] = '{7, 13, 5, 100};

  freq_meas_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_mask(ch_mask), .gate_len(gate_len),
    .continuous(continuous), .fc_en(fc_en), .fc_sel(fc_sel), .fc_vld(fc_vld), .fc_cnt(fc_cnt),
    .res_vld(res_vld), .res_ready(res_ready), .res_ch(res_ch), .res_cnt(res_cnt),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Counter model: counts one-cycle pulses while en is high, replies 2 cycles after en falls.
  always @(negedge clk) begin
    cyc_m++;
    fc_vld = 1'b0;
    if (!rst_n) begin
      cnt_m = 0; en_seen = 0; dly = 0; en_run = 0;
    end else if (fc_en) begin
      en_run++; en_seen = 1; dly = 0;
      if (cyc_m % period[fc_sel] == 0) cnt_m++;
    end else begin
      if (en_run > 0) begin last_en_len = en_run; en_run = 0; end
      if (en_seen) begin
        dly++;
        if (dly == 2) begin
          en_seen = 0;
          if (model_en) begin fc_vld = 1'b1; fc_cnt = CNT_W'(cnt_m); end
          cnt_m = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic do_start(input logic [N_CH-1:0] m, input int g, input bit c);
    start = 1'b1; ch_mask = m; gate_len = GATE_W'(g); continuous = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_res(input int limit, output int n);
    n = 0;
    while (res_vld !== 1'b1 && n < limit) begin tick(); n++; end
  endtask

  task automatic wait_en(input logic lvl, input int limit);
    int n = 0;
    while (fc_en !== lvl && n < limit) begin tick(); n++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2500;
    checks++; if (fc_en !== 1'b0)  begin errors++; $display("FAIL reset_fc_en got %b want 0", fc_en); end
    checks++; if (fc_sel !== '0)   begin errors++; $display("FAIL reset_fc_sel got %0d want 0", fc_sel); end
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL reset_res_vld got %b want 0", res_vld); end
    checks++; if (res_ch !== '0)   begin errors++; $display("FAIL reset_res_ch got %0d want 0", res_ch); end
    checks++; if (res_cnt !== '0)  begin errors++; $display("FAIL reset_res_cnt got %0d want 0", res_cnt); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err got %b want 0", res_err); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_two_channels();
    int n;
    res_ready = 1'b1;
    do_start(4'b0101, 300, 1'b0);
    wait_res(1000, n);
    checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL two_ch_res0_timeout got %b want 1", res_vld); end
    checks++; if (n != 306) begin errors++; $display("FAIL two_ch_latency got %0d want 306", n); end
    checks++; if (res_ch !== 2'd0) begin errors++; $display("FAIL two_ch_first_ch got %0d want 0", res_ch); end
    checks++; if (last_en_len != 300) begin errors++; $display("FAIL two_ch_gate0 got %0d want 300", last_en_len); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL two_ch_err got %b want 0", res_err); end
    tick();
    wait_res(1000, n);
    checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL two_ch_res1_timeout got %b want 1", res_vld); end
    checks++; if (res_ch !== 2'd2) begin errors++; $display("FAIL two_ch_second_ch got %0d want 2", res_ch); end
    checks++; if (last_en_len != 300) begin errors++; $display("FAIL two_ch_gate1 got %0d want 300", last_en_len); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL two_ch_idle got %b want 0", busy); end
  endtask

  task automatic test_frequency();
    int n;
    do_start(4'b1000, 1000, 1'b0);
    wait_res(2000, n);
    checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL freq_timeout got %b want 1", res_vld); end
    checks++; if (res_ch !== 2'd3) begin errors++; $display("FAIL freq_ch got %0d want 3", res_ch); end
    checks++;
    if (res_cnt < 16'd9 || res_cnt > 16'd11) begin errors++; $display("FAIL freq_cnt got %0d want 10+-1", res_cnt); end
    tick();
  endtask

  task automatic test_back_pressure();
    int n;
    logic [CH_W-1:0] c0;
    logic [CNT_W-1:0] k0;
    res_ready = 1'b0;
    do_start(4'b0011, 20, 1'b0);
    wait_res(200, n);
    checks++; if (res_vld !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b want 1", res_vld); end
    checks++; if (res_ch !== 2'd0) begin errors++; $display("FAIL bp_ch got %0d want 0", res_ch); end
    c0 = res_ch; k0 = res_cnt;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (res_vld !== 1'b1 || res_ch !== c0 || res_cnt !== k0 || fc_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got vld=%b ch=%0d cnt=%0d en=%b want 1/%0d/%0d/0",
                 i, res_vld, res_ch, res_cnt, fc_en, c0, k0);
      end
    end
    res_ready = 1'b1;
    tick();
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL bp_vld_clear got %b want 0", res_vld); end
    n = 0;
    while (fc_en !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n != SETTLE) begin errors++; $display("FAIL bp_settle got %0d want %0d", n, SETTLE); end
    wait_res(200, n);
    checks++; if (res_ch !== 2'd1 || res_vld !== 1'b1) begin errors++; $display("FAIL bp_next_ch got %0d want 1", res_ch); end
    tick();
  endtask

  task automatic test_edges();
    int n;
    do_start(4'b0000, 10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL edge_mask0_busy got %b want 0", busy); end
      tick();
    end
    do_start(4'b0001, 40, 1'b0);
    wait_en(1'b1, 20);
    repeat (5) tick();
    do_start(4'b1111, 5, 1'b0);
    wait_res(200, n);
    checks++; if (res_ch !== 2'd0 || res_vld !== 1'b1) begin errors++; $display("FAIL edge_gate_start_ch got %0d want 0", res_ch); end
    checks++; if (last_en_len != 40) begin errors++; $display("FAIL edge_gate_len got %0d want 40", last_en_len); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL edge_gate_start_idle got %b want 0", busy); end
    do_start(4'b0010, 0, 1'b0);
    wait_res(200, n);
    checks++; if (res_ch !== 2'd1 || res_vld !== 1'b1) begin errors++; $display("FAIL edge_gate0_ch got %0d want 1", res_ch); end
    checks++; if (last_en_len != 1) begin errors++; $display("FAIL edge_gate0_len got %0d want 1", last_en_len); end
    tick();
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    do_start(4'b0001, 100, 1'b0);
    wait_en(1'b1, 20);
    repeat (10) tick();
    checks++; if (fc_en !== 1'b1) begin errors++; $display("FAIL arst_pre_en got %b want 1", fc_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (fc_en !== 1'b0) begin errors++; $display("FAIL arst_fc_en got %b want 0", fc_en); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int i = 0; i < 400; i++) begin
      if (res_vld === 1'b1 || fc_en === 1'b1) seen = 1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL arst_spurious got 1 want 0"); end
  endtask

  task automatic test_continuous();
    int n;
    res_ready = 1'b1;
    do_start(4'b0011, 10, 1'b1);
    for (int r = 0; r < 4; r++) begin
      wait_res(200, n);
      checks++;
      if (res_vld !== 1'b1 || res_ch !== CH_W'(r % 2)) begin
        errors++; $display("FAIL cont_order r=%0d got ch=%0d vld=%b want ch=%0d", r, res_ch, res_vld, r % 2);
      end
      if (r == 2) continuous = 1'b0;
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_stop got %b want 0", busy); end
  endtask

`ifdef FMS_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    model_en = 0;
    res_ready = 1'b1;
    do_start(4'b0011, 10, 1'b1);
    for (int r = 0; r < 4; r++) begin
      wait_en(1'b1, 50);
      wait_en(1'b0, 50);
      wait_res(200, n);
      checks++; if (n != 64) begin errors++; $display("FAIL tmo_latency r=%0d got %0d want 64", r, n); end
      checks++;
      if (res_err !== 1'b1 || res_cnt !== '0 || res_ch !== CH_W'(r % 2)) begin
        errors++; $display("FAIL tmo_result r=%0d got err=%b cnt=%0d ch=%0d want 1/0/%0d", r, res_err, res_cnt, res_ch, r % 2);
      end
      if (r == 2) continuous = 1'b0;
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_stop got %b want 0", busy); end
    model_en = 1;
  endtask
`else
  task automatic test_timeout();
    model_en = 0;
    do_start(4'b0001, 10, 1'b0);
    repeat (300) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nowait_busy got %b want 1", busy); end
    checks++; if (res_vld !== 1'b0 || res_err !== 1'b0) begin
      errors++; $display("FAIL nowait_res got vld=%b err=%b want 0/0", res_vld, res_err);
    end
    rst_n = 1'b0;
    tick();
    @(negedge clk); rst_n = 1'b1;
    model_en = 1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nowait_reset got %b want 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_channels();
    test_frequency();
    test_back_pressure();
    test_edges();
    test_async_reset();
    test_continuous();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
